// File: rtl/tone_sequencer.sv
// tone_sequencer
//   Plays a short melody from a small note table by driving a DDS tone
//   generator. Each table entry holds a frequency control word (fcw) and a
//   duration counted in audio-rate sample strobes. A free-running divider
//   turns the system clock into that sample strobe.
//
//   Optional feature: define TONE_SEQ_LOOP_EN to add the i_loop input.
//   With i_loop high, playback wraps from the last entry back to entry 0
//   and never issues o_done. Without the macro, playback is always one-shot.
//
// Parameters
//   CLK_DIV  system clocks per audio sample (2..65535)
//   DEPTH    note table entries (power of two, 2..16)
//
// Ports
//   i_clk         system clock
//   i_rst         synchronous active-high reset
//   i_start       one-cycle pulse, begin playback at entry 0
//   i_stop        one-cycle pulse, abort playback (wins over i_start)
//   i_len         entries to play, sampled at start (0 -> 1, >DEPTH -> DEPTH)
//   i_wr_*        table write port, one entry per cycle, any state
//   i_loop        (TONE_SEQ_LOOP_EN only) repeat the sequence
//   o_sample_req  one-clock strobe every CLK_DIV clocks
//   o_fcw         frequency control word for the DDS, 0 when silent
//   o_busy        high in every state except IDLE
//   o_step        index of the entry being loaded or played
//   o_done        one-cycle pulse on normal completion
module tone_sequencer #(
    parameter int CLK_DIV = 1000,
    parameter int DEPTH   = 8,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_stop,
    input  logic [AW:0]   i_len,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [15:0]   i_wr_fcw,
    input  logic [15:0]   i_wr_dur,
`ifdef TONE_SEQ_LOOP_EN
    input  logic          i_loop,
`endif
    output logic          o_sample_req,
    output logic [15:0]   o_fcw,
    output logic          o_busy,
    output logic [AW-1:0] o_step,
    output logic          o_done
);

    localparam logic [15:0] DIV_MAX = 16'(CLK_DIV - 1);
    localparam logic [15:0] DIV_PRE = 16'(CLK_DIV - 2);
    localparam logic [AW:0] LEN_ONE = (AW+1)'(1);
    localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, DONE} state_t;

    state_t        state, state_nxt;
    logic [15:0]   fcw_mem [DEPTH];
    logic [15:0]   dur_mem [DEPTH];
    logic [15:0]   div_cnt;
    logic          sample_req;
    logic [AW:0]   len, len_nxt;
    logic [15:0]   dur_cnt, dur_nxt;
    logic [15:0]   fcw, fcw_nxt;
    logic [AW-1:0] step, step_nxt;
    logic          busy;
    logic          done, done_nxt;
    logic          last_note;
    logic          loop_now;

    // Saturate the requested length into 1..DEPTH.
    function automatic logic [AW:0] clamp_len(input logic [AW:0] raw);
        if (raw == '0)
            return LEN_ONE;
        else if (raw > LEN_MAX)
            return LEN_MAX;
        else
            return raw;
    endfunction

    // A zero duration still plays for one strobe.
    function automatic logic [15:0] floor_dur(input logic [15:0] raw);
        return (raw == 16'd0) ? 16'd1 : raw;
    endfunction

`ifdef TONE_SEQ_LOOP_EN
    assign loop_now = i_loop;
`else
    assign loop_now = 1'b0;
`endif

    // Sample-rate divider: free-running, independent of the FSM. The strobe
    // is registered one count early so it lines up with count == CLK_DIV-1.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            div_cnt    <= '0;
            sample_req <= 1'b0;
        end else begin
            div_cnt    <= (div_cnt == DIV_MAX) ? 16'd0 : div_cnt + 16'd1;
            sample_req <= (div_cnt == DIV_PRE);
        end
    end

    // Note table: no reset, contents survive i_rst. The asynchronous read
    // below sees the old word when a write hits the same address.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            fcw_mem[i_wr_addr] <= i_wr_fcw;
            dur_mem[i_wr_addr] <= i_wr_dur;
        end
    end

    assign last_note = ({1'b0, step} == (len - LEN_ONE));

    always_comb begin
        state_nxt = state;
        fcw_nxt   = fcw;
        step_nxt  = step;
        dur_nxt   = dur_cnt;
        len_nxt   = len;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                fcw_nxt  = '0;
                step_nxt = '0;
                if (i_start && !i_stop) begin
                    state_nxt = LOAD;
                    len_nxt   = clamp_len(i_len);
                end
            end
            LOAD: begin
                fcw_nxt   = fcw_mem[step];
                dur_nxt   = floor_dur(dur_mem[step]);
                state_nxt = PLAY;
            end
            PLAY: begin
                // Strobes arriving during LOAD never reach this branch, so
                // each note spans exactly its duration in counted strobes.
                if (sample_req) begin
                    if (dur_cnt == 16'd1) begin
                        if (!last_note) begin
                            step_nxt  = step + AW'(1);
                            state_nxt = LOAD;
                        end else if (loop_now) begin
                            step_nxt  = '0;
                            state_nxt = LOAD;
                        end else begin
                            fcw_nxt   = '0;
                            done_nxt  = 1'b1;
                            state_nxt = DONE;
                        end
                    end else begin
                        dur_nxt = dur_cnt - 16'd1;
                    end
                end
            end
            DONE: begin
                fcw_nxt   = '0;
                step_nxt  = '0;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Abort from any active state; in IDLE a simultaneous start is
        // already suppressed above.
        if (i_stop && state != IDLE) begin
            state_nxt = IDLE;
            fcw_nxt   = '0;
            step_nxt  = '0;
            done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            fcw   <= '0;
            step  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            fcw   <= fcw_nxt;
            step  <= step_nxt;
            busy  <= (state_nxt != IDLE);
            done  <= done_nxt;
        end
    end

    // Working registers, always loaded before they are used.
    always_ff @(posedge i_clk) begin
        dur_cnt <= dur_nxt;
        len     <= len_nxt;
    end

    assign o_sample_req = sample_req;
    assign o_fcw        = fcw;
    assign o_busy       = busy;
    assign o_step       = step;
    assign o_done       = done;

endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer
//   Directed bench for tone_sequencer with CLK_DIV=4, DEPTH=8. Expected
//   values are cycle offsets worked out by hand from the start pulse; start
//   pulses are aligned so the start cycle N has N mod 4 == 0, which puts the
//   sample strobes at offsets 3, 7, 11, ... The loop-mode section is built
//   only when TONE_SEQ_LOOP_EN is defined.
module tb_tone_sequencer;

    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 8;
    localparam int AW      = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [AW:0]   len = '0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [15:0]   wr_fcw = '0;
    logic [15:0]   wr_dur = '0;
`ifdef TONE_SEQ_LOOP_EN
    logic          loop = 1'b0;
`endif
    logic          sample_req;
    logic [15:0]   fcw;
    logic          busy;
    logic [AW-1:0] step;
    logic          done;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    tone_sequencer #(.CLK_DIV(CLK_DIV), .DEPTH(DEPTH)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_stop      (stop),
        .i_len       (len),
        .i_wr_en     (wr_en),
        .i_wr_addr   (wr_addr),
        .i_wr_fcw    (wr_fcw),
        .i_wr_dur    (wr_dur),
`ifdef TONE_SEQ_LOOP_EN
        .i_loop      (loop),
`endif
        .o_sample_req(sample_req),
        .o_fcw       (fcw),
        .o_busy      (busy),
        .o_step      (step),
        .o_done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic align0();
        while (cyc % CLK_DIV != 0) tick();
    endtask

    task automatic write_entry(input int a, input int f, input int d);
        wr_en   = 1'b1;
        wr_addr = a[AW-1:0];
        wr_fcw  = f[15:0];
        wr_dur  = d[15:0];
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic [15:0]   fcw_e;
        logic          seen;
        logic [AW-1:0] max_step;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;

        // Reset state and divider cadence.
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fcw", fcw, 0);
        check("rst_step", step, 0);
        for (int c = 0; c < 20; c++) begin
            check("div_strobe", sample_req, (c % 4 == 3));
            tick();
        end

        // Fill the table.
        write_entry(0, 16'h1000, 2);
        write_entry(1, 16'h2000, 3);
        for (int i = 2; i < DEPTH; i++) write_entry(i, 16'h3000 + i, 1);

        // Two-note one-shot playback.
        align0();
        len = 4'd2;
        pulse_start();
        for (int k = 1; k <= 21; k++) begin
            fcw_e = (k < 2) ? 16'h0 : (k <= 8) ? 16'h1000 : (k <= 19) ? 16'h2000 : 16'h0;
            check("play_fcw", fcw, fcw_e);
            if (k <= 19 || k == 21) check("play_step", step, (k >= 8 && k <= 19) ? 1 : 0);
            check("play_busy", busy, (k <= 20));
            check("play_done", done, (k == 20));
            if (k < 21) tick();
        end

        // Stop during the second strobe of entry 1.
        align0();
        pulse_start();
        for (int k = 1; k < 15; k++) tick();
        check("stop_pre_fcw", fcw, 16'h2000);
        check("stop_pre_step", step, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_busy", busy, 0);
        check("stop_fcw", fcw, 0);
        check("stop_step", step, 0);
        seen = done;
        for (int k = 0; k < 8; k++) begin
            tick();
            seen = seen | done;
        end
        check("stop_no_done", seen, 0);

        // Start and stop together stay idle.
        align0();
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("ss_busy", busy, 0);
        tick();
        check("ss_busy2", busy, 0);
        check("ss_fcw", fcw, 0);

        // Start while playing is ignored.
        align0();
        pulse_start();
        repeat (3) tick();
        check("ign_pre_fcw", fcw, 16'h1000);
        pulse_start();
        check("ign_step", step, 0);
        check("ign_fcw", fcw, 16'h1000);
        check("ign_busy", busy, 1);
        repeat (3) tick();
        check("ign_step_adv", step, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("ign_stop_busy", busy, 0);

        // Zero duration and zero length play one strobe of entry 0.
        write_entry(0, 16'h4000, 0);
        len = 4'd0;
        align0();
        pulse_start();
        tick();
        check("z_fcw2", fcw, 16'h4000);
        tick();
        check("z_fcw3", fcw, 16'h4000);
        check("z_done3", done, 0);
        tick();
        check("z_done4", done, 1);
        check("z_fcw4", fcw, 0);
        tick();
        check("z_done5", done, 0);
        check("z_busy5", busy, 0);

        // Write to the loaded address during LOAD: old word is played.
        len = 4'd1;
        align0();
        pulse_start();
        wr_en   = 1'b1;
        wr_addr = '0;
        wr_fcw  = 16'h5555;
        wr_dur  = 16'd1;
        tick();
        wr_en   = 1'b0;
        check("rbw_old", fcw, 16'h4000);
        repeat (3) tick();
        check("rbw_idle", busy, 0);
        align0();
        pulse_start();
        tick();
        check("rbw_new", fcw, 16'h5555);
        repeat (3) tick();

        // Length above DEPTH clamps to DEPTH entries.
        len = 4'd15;
        align0();
        pulse_start();
        seen = 1'b0;
        max_step = '0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (done) seen = 1'b1;
            if (step > max_step) max_step = step;
            tick();
        end
        check("clamp_done", seen, 1);
        check("clamp_max_step", max_step, 7);
        tick();

        // Reset mid-playback.
        len = 4'd2;
        align0();
        pulse_start();
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cyc = 0;
        check("mrst_busy", busy, 0);
        check("mrst_fcw", fcw, 0);
        check("mrst_step", step, 0);
        check("mrst_done", done, 0);
        check("mrst_sreq", sample_req, 0);
        seen = 1'b0;
        repeat (3) begin
            tick();
            seen = seen | done;
        end
        check("mrst_no_done", seen, 0);
        check("mrst_strobe3", sample_req, 1);
        len = 4'd1;
        align0();
        pulse_start();
        tick();
        check("mrst_table_kept", fcw, 16'h5555);
        repeat (4) tick();

`ifdef TONE_SEQ_LOOP_EN
        // Loop mode: 0,1,0,1,... without done, then finish after entry 1.
        begin
            logic [AW-1:0] prev;
            logic [AW-1:0] seq [4];
            int            nseq;
            write_entry(0, 16'h1000, 2);
            write_entry(1, 16'h2000, 3);
            loop = 1'b1;
            len  = 4'd2;
            align0();
            pulse_start();
            prev = step;
            nseq = 0;
            seen = 1'b0;
            for (int i = 0; i < 120; i++) begin
                tick();
                seen = seen | done;
                if (step != prev && nseq < 4) begin
                    seq[nseq] = step;
                    nseq++;
                end
                prev = step;
            end
            check("loop_nseq", nseq, 4);
            check("loop_seq0", seq[0], 1);
            check("loop_seq1", seq[1], 0);
            check("loop_seq2", seq[2], 1);
            check("loop_seq3", seq[3], 0);
            check("loop_no_done", seen, 0);
            loop = 1'b0;
            seen = 1'b0;
            for (int i = 0; i < 100 && !seen; i++) begin
                tick();
                if (done) begin
                    seen = 1'b1;
                    check("loop_end_fcw", fcw, 0);
                end
            end
            check("loop_end_done", seen, 1);
            tick();
            check("loop_end_busy", busy, 0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tone_sequencer.md
TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1000, meaning system clocks per audio sample (48 MHz / 48 kHz); legal range 2..65535.
REQ-002 SHALL have parameter DEPTH, default 8, meaning note table entries (power of two, 2..16); AW = log2(DEPTH).
REQ-003 i_clk  in  1  system clock (48 MHz); single clock domain.
REQ-004 i_rst  in  1  synchronous, active-high reset.
REQ-005 i_start  in  1  one-cycle pulse; begins playback from entry 0.
REQ-006 i_stop  in  1  one-cycle pulse; aborts playback.
REQ-007 i_len  in  AW+1  number of entries to play, sampled at start; 0 treated as 1, values >DEPTH treated as DEPTH.
REQ-008 i_wr_en, i_wr_addr[AW-1:0], i_wr_fcw[15:0], i_wr_dur[15:0]  in  table write port; writes one entry per cycle.
REQ-009 o_sample_req  out  1  audio-rate strobe to the DDS tone generator.
REQ-010 o_fcw  out  16  frequency control word to the DDS tone generator; registered.
REQ-011 o_busy  out  1  high in every state except IDLE.
REQ-012 o_step  out  AW  index of entry currently loaded or playing; registered.
REQ-013 o_done  out  1  one-cycle pulse on normal completion.

Function
REQ-014 Divider counts 0..CLK_DIV-1 free-running from reset; o_sample_req is high for exactly one clock when the count equals CLK_DIV-1; the divider is unaffected by start, stop or state.
REQ-015 FSM states: IDLE, LOAD, PLAY, DONE; all outputs registered.
REQ-016 IDLE: o_fcw=0, o_step=0; i_start (without i_stop) -> LOAD next cycle, latch clamped i_len.
REQ-017 LOAD (exactly 1 cycle): read table[o_step]; load o_fcw=fcw, dur_cnt=dur (0 treated as 1) -> PLAY.
REQ-018 PLAY: dur_cnt decrements on each o_sample_req; on the strobe with dur_cnt==1: if o_step==len-1 -> DONE, else o_step+1 -> LOAD.
REQ-019 Strobes coinciding with LOAD are not counted; a note therefore lasts exactly dur counted strobes in PLAY.
REQ-020 DONE (exactly 1 cycle): o_done=1, o_fcw=0 -> IDLE.
REQ-021 Latency: i_start at cycle N -> o_busy=1 at N+1 (LOAD), o_fcw=table[0].fcw at N+2.
REQ-022 i_stop in LOAD/PLAY/DONE -> IDLE next cycle, o_fcw=0, o_step=0, no o_done pulse.
REQ-023 i_start and i_stop in the same cycle: stop wins; i_start while o_busy=1 is ignored.
REQ-024 Table writes are accepted in any state; LOAD reads the pre-write value when i_wr_addr equals the loaded address in the same cycle (read-before-write).
REQ-025 Table contents are not reset; the bench writes every entry before use.

Reset
REQ-026 i_rst forces IDLE, divider=0, o_sample_req=0, o_fcw=0, o_step=0, o_busy=0, o_done=0 on the next clock edge.
REQ-027 Reset mid-playback aborts immediately, with no o_done pulse; table contents are retained.

Configuration
REQ-028 With TONE_SEQ_LOOP_EN defined: input port i_loop (1 bit) is added; when i_loop=1 at the last note's final strobe, the FSM goes to LOAD with o_step=0 instead of DONE, and no o_done pulse is issued; i_loop=0 behaves as the one-shot mode.
REQ-029 Without TONE_SEQ_LOOP_EN: no i_loop port; playback is always one-shot.

Verification (CLK_DIV=4, DEPTH=8)
REQ-030 After reset, run 20 clocks -> o_sample_req pulses at cycles 3, 7, 11, 15, 19, each exactly 1 clock wide.
REQ-031 Table {0:(0x1000,2), 1:(0x2000,3)}, i_len=2, i_start -> o_fcw=0x1000 for 2 counted strobes, 1-cycle LOAD, then 0x2000 for 3 strobes, then a single o_done pulse, o_fcw=0, o_busy=0.
REQ-032 Same table; i_stop during the 2nd strobe of entry 1 -> IDLE next cycle, o_fcw=0, o_done never asserted.
REQ-033 i_start+i_stop in the same cycle -> stays IDLE; i_start during PLAY -> o_step and o_fcw unchanged.
REQ-034 Entry dur=0, i_len=0 -> plays entry 0 for exactly 1 strobe, then o_done.
REQ-035 TONE_SEQ_LOOP_EN defined, i_loop=1, i_len=2 -> o_step sequence 0,1,0,1... with o_done never pulsing; drop i_loop -> o_done after the next entry 1 completes.
